cachemem_wb: RTL and testbench

- Parametrised direct-mapped data-cache array with per-line valid and dirty state.
- Provides a combinational lookup port, a CPU store port (marks the line dirty) and a memory fill port (clean).
- A one-entry writeback buffer captures evicted dirty victims and drains them to the memory side over a valid/ready handshake.
- Sits between the D-cache controller and the memory arbiter.

---
 rtl/cachemem_wb.sv | 183 ++++++++++++++++++
 tb/tb_cachemem_wb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cachemem_wb.sv
// Direct-mapped data-cache array with valid/dirty state and a one-entry writeback buffer.
// Optional whole-cache flush engine enabled by defining CACHEMEM_FLUSH_EN.
module cachemem_wb #(
  parameter int IDX_BITS  = 7,
  parameter int TAG_BITS  = 22,
  parameter int DATA_BITS = 64
) (
  input  logic                         clock,
  input  logic                         reset,
`ifdef CACHEMEM_FLUSH_EN
  input  logic                         flush_req,
  output logic                         flush_busy,
  output logic                         flush_done,
`endif
  input  logic [IDX_BITS-1:0]          rd_idx,
  input  logic [TAG_BITS-1:0]          rd_tag,
  output logic [DATA_BITS-1:0]         rd_data,
  output logic                         rd_hit,
  input  logic                         st_en,
  input  logic [IDX_BITS-1:0]          st_idx,
  input  logic [TAG_BITS-1:0]          st_tag,
  input  logic [DATA_BITS-1:0]         st_data,
  output logic                         st_ready,
  input  logic                         fill_en,
  input  logic [IDX_BITS-1:0]          fill_idx,
  input  logic [TAG_BITS-1:0]          fill_tag,
  input  logic [DATA_BITS-1:0]         fill_data,
  output logic                         fill_ready,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [TAG_BITS+IDX_BITS-1:0] wb_addr,
  output logic [DATA_BITS-1:0]         wb_data
);

  localparam int NSETS = 2 ** IDX_BITS;

  logic [TAG_BITS-1:0]  tag_q  [NSETS];
  logic [DATA_BITS-1:0] data_q [NSETS];
  logic [NSETS-1:0]     valid_q;
  logic [NSETS-1:0]     dirty_q;

  logic                          evict_st, evict_fill, buf_free, fill_keep;
  logic                          st_acc, fill_acc, busy;
  logic                          scan_cap;
  logic [IDX_BITS-1:0]           scan_idx;
  logic                          cap_en;
  logic [TAG_BITS+IDX_BITS-1:0]  cap_addr;
  logic [DATA_BITS-1:0]          cap_data;

  assign rd_data = data_q[rd_idx];
  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign evict_st   = valid_q[st_idx] && dirty_q[st_idx] && (tag_q[st_idx] != st_tag);
  assign evict_fill = valid_q[fill_idx] && dirty_q[fill_idx] && (tag_q[fill_idx] != fill_tag);
  // A fill onto a dirty line with the same tag must not clobber newer store data.
  assign fill_keep  = valid_q[fill_idx] && dirty_q[fill_idx] && (tag_q[fill_idx] == fill_tag);
  assign buf_free   = !wb_valid || wb_ready;

  assign st_ready   = (!evict_st || buf_free) && !busy;
  assign fill_ready = !(st_en && (st_idx == fill_idx))
                   && !(evict_fill && !buf_free)
                   && !(evict_fill && st_en && evict_st)
                   && !busy;

  assign st_acc   = st_en && st_ready;
  assign fill_acc = fill_en && fill_ready;

`ifdef CACHEMEM_FLUSH_EN
  typedef enum logic [1:0] {IDLE, SCAN, DONE} flush_state_t;

  flush_state_t        state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  logic                advance;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    scan_cap = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      IDLE: if (flush_req) begin
        state_d = SCAN;
        ptr_d   = '0;
      end
      SCAN: begin
        if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
          scan_cap = buf_free;
          advance  = buf_free;
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          if (&ptr_q) state_d = DONE;
          else        ptr_d   = ptr_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign scan_idx   = ptr_q;
  assign busy       = (state_q != IDLE);
  assign flush_busy = busy;
  assign flush_done = (state_q == DONE);
`else
  assign scan_cap = 1'b0;
  assign scan_idx = '0;
  assign busy     = 1'b0;
`endif

  // At most one source evicts per cycle: a colliding fill is held off while the store owns the buffer.
  always_comb begin
    cap_en   = 1'b0;
    cap_addr = '0;
    cap_data = '0;
    if (st_acc && evict_st) begin
      cap_en   = 1'b1;
      cap_addr = {tag_q[st_idx], st_idx};
      cap_data = data_q[st_idx];
    end else if (fill_acc && evict_fill) begin
      cap_en   = 1'b1;
      cap_addr = {tag_q[fill_idx], fill_idx};
      cap_data = data_q[fill_idx];
    end else if (scan_cap) begin
      cap_en   = 1'b1;
      cap_addr = {tag_q[scan_idx], scan_idx};
      cap_data = data_q[scan_idx];
    end
  end

  // NOTE: tag/data arrays carry no reset; valid_q gates every use of them, so they can map to plain RAM.
  always_ff @(posedge clock) begin
    if (st_acc) begin
      tag_q[st_idx]  <= st_tag;
      data_q[st_idx] <= st_data;
    end
    if (fill_acc && !fill_keep) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (st_acc) begin
        valid_q[st_idx] <= 1'b1;
        dirty_q[st_idx] <= 1'b1;
      end
      if (fill_acc && !fill_keep) begin
        valid_q[fill_idx] <= 1'b1;
        dirty_q[fill_idx] <= 1'b0;
      end
      if (scan_cap) dirty_q[scan_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid <= 1'b0;
    end else if (cap_en) begin
      wb_valid <= 1'b1;
      wb_addr  <= cap_addr;
      wb_data  <= cap_data;
    end else if (wb_valid && wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cachemem_wb.sv
// Directed self-checking bench for cachemem_wb; flush scenario runs when CACHEMEM_FLUSH_EN is defined.
module tb_cachemem_wb;
  localparam int IB = 7;
  localparam int TB = 22;
  localparam int DB = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic [IB-1:0] rd_idx, st_idx, fill_idx;
  logic [TB-1:0] rd_tag, st_tag, fill_tag;
  logic [DB-1:0] rd_data, st_data, fill_data, wb_data;
  logic          rd_hit, st_en, st_ready, fill_en, fill_ready, wb_valid, wb_ready;
  logic [TB+IB-1:0] wb_addr;
`ifdef CACHEMEM_FLUSH_EN
  logic          flush_req, flush_busy, flush_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  cachemem_wb #(.IDX_BITS(IB), .TAG_BITS(TB), .DATA_BITS(DB)) dut (
    .clock(clock), .reset(reset),
`ifdef CACHEMEM_FLUSH_EN
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
`endif
    .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_data(rd_data), .rd_hit(rd_hit),
    .st_en(st_en), .st_idx(st_idx), .st_tag(st_tag), .st_data(st_data), .st_ready(st_ready),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data),
    .fill_ready(fill_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] addr(input int t, input int i);
    logic [TB+IB-1:0] a;
    a = {TB'(t), IB'(i)};
    return 64'(a);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input int i, input int t);
    rd_idx = IB'(i);
    rd_tag = TB'(t);
    #1;
  endtask

  task automatic store(input int i, input int t, input logic [63:0] d);
    st_en = 1'b1; st_idx = IB'(i); st_tag = TB'(t); st_data = d;
    #1;
  endtask

  task automatic fill(input int i, input int t, input logic [63:0] d);
    fill_en = 1'b1; fill_idx = IB'(i); fill_tag = TB'(t); fill_data = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; st_en = 1'b0; fill_en = 1'b0; wb_ready = 1'b0;
    rd_idx = '0; rd_tag = '0; st_idx = '0; st_tag = '0; st_data = '0;
    fill_idx = '0; fill_tag = '0; fill_data = '0;
`ifdef CACHEMEM_FLUSH_EN
    flush_req = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;

    rd(5, 3);
    check("reset_hit", 64'(rd_hit), 64'd0);
    check("reset_wbv", 64'(wb_valid), 64'd0);

    store(5, 3, 64'hAA);
    check("st_rdy_clean", 64'(st_ready), 64'd1);
    tick(); st_en = 1'b0; #1;
    check("st_hit", 64'(rd_hit), 64'd1);
    check("st_data", rd_data, 64'hAA);
    check("st_no_wb", 64'(wb_valid), 64'd0);

    fill(5, 3, 64'hBB);
    check("fill_same_rdy", 64'(fill_ready), 64'd1);
    tick(); fill_en = 1'b0; #1;
    check("fill_keep_data", rd_data, 64'hAA);
    check("fill_keep_hit", 64'(rd_hit), 64'd1);

    store(6, 4, 64'h66);
    tick(); st_en = 1'b0;
    store(5, 9, 64'hCC);
    check("evict_st_rdy", 64'(st_ready), 64'd1);
    tick(); st_en = 1'b0; rd(5, 9);
    check("evict_wbv", 64'(wb_valid), 64'd1);
    check("evict_addr", 64'(wb_addr), addr(3, 5));
    check("evict_data", wb_data, 64'hAA);
    check("evict_new_data", rd_data, 64'hCC);

    store(6, 8, 64'h77);
    for (int c = 0; c < 3; c++) begin
      check("hold_st_rdy", 64'(st_ready), 64'd0);
      tick();
      check("hold_wbv", 64'(wb_valid), 64'd1);
      check("hold_addr", 64'(wb_addr), addr(3, 5));
      check("hold_data", wb_data, 64'hAA);
    end
    st_en = 1'b0; wb_ready = 1'b1;
    tick(); wb_ready = 1'b0; #1;
    check("drain_wbv", 64'(wb_valid), 64'd0);

    store(7, 1, 64'h71);
    fill(7, 2, 64'h72);
    check("coll_st_rdy", 64'(st_ready), 64'd1);
    check("coll_fill_rdy", 64'(fill_ready), 64'd0);
    tick(); st_en = 1'b0; fill_en = 1'b0; rd(7, 1);
    check("coll_hit", 64'(rd_hit), 64'd1);
    check("coll_data", rd_data, 64'h71);
    store(7, 5, 64'h75);
    tick(); st_en = 1'b0; #1;
    check("coll_dirty_wbv", 64'(wb_valid), 64'd1);
    check("coll_dirty_addr", 64'(wb_addr), addr(1, 7));
    check("coll_dirty_data", wb_data, 64'h71);

    wb_ready = 1'b1;
    fill(6, 10, 64'h6A);
    check("swap_fill_rdy", 64'(fill_ready), 64'd1);
    tick(); fill_en = 1'b0; wb_ready = 1'b0; rd(6, 10);
    check("swap_wbv", 64'(wb_valid), 64'd1);
    check("swap_addr", 64'(wb_addr), addr(4, 6));
    check("swap_data", wb_data, 64'h66);
    check("swap_fill_hit", 64'(rd_hit), 64'd1);
    check("swap_fill_data", rd_data, 64'h6A);
    wb_ready = 1'b1;
    tick(); wb_ready = 1'b0; #1;
    check("swap_drain", 64'(wb_valid), 64'd0);

    fill(6, 11, 64'h6B);
    check("clean_fill_rdy", 64'(fill_ready), 64'd1);
    tick(); fill_en = 1'b0; rd(6, 11);
    check("clean_fill_nowb", 64'(wb_valid), 64'd0);
    check("clean_fill_hit", 64'(rd_hit), 64'd1);

    store(5, 12, 64'hDD);
    tick(); st_en = 1'b0; #1;
    check("pre_rst_wbv", 64'(wb_valid), 64'd1);
    reset = 1'b1;
    tick(); reset = 1'b0; rd(5, 12);
    check("mid_rst_wbv", 64'(wb_valid), 64'd0);
    check("mid_rst_hit", 64'(rd_hit), 64'd0);

`ifdef CACHEMEM_FLUSH_EN
    begin
      logic [63:0] seen [$];
      int done_cnt;
      bit  finished;
      done_cnt = 0;
      finished = 1'b0;
      store(0, 21, 64'hD0);  tick();
      store(64, 21, 64'hD1); tick();
      store(127, 21, 64'hD2); tick();
      st_en = 1'b0;
      wb_ready = 1'b1;
      flush_req = 1'b1;
      tick(); flush_req = 1'b0; #1;
      check("flush_busy", 64'(flush_busy), 64'd1);
      store(3, 1, 64'h33);
      check("flush_st_block", 64'(st_ready), 64'd0);
      st_en = 1'b0;
      for (int c = 0; c < 400 && !finished; c++) begin
        if (wb_valid) seen.push_back(64'(wb_addr));
        if (flush_done) done_cnt++;
        if (done_cnt > 0 && !flush_busy) finished = 1'b1;
        else tick();
      end
      check("flush_timeout", 64'(finished), 64'd1);
      check("flush_xfers", 64'(seen.size()), 64'd3);
      if (seen.size() == 3) begin
        check("flush_addr0", seen[0], addr(21, 0));
        check("flush_addr1", seen[1], addr(21, 64));
        check("flush_addr2", seen[2], addr(21, 127));
      end
      check("flush_done_cnt", 64'(done_cnt), 64'd1);
      wb_ready = 1'b0;
      rd(0, 21);   check("flush_hit0", 64'(rd_hit), 64'd1);
      rd(64, 21);  check("flush_hit64", 64'(rd_hit), 64'd1);
      rd(127, 21); check("flush_hit127", 64'(rd_hit), 64'd1);
      store(0, 22, 64'hE0);
      tick(); st_en = 1'b0; #1;
      check("flush_clean0", 64'(wb_valid), 64'd0);
      store(127, 22, 64'hE2);
      tick(); st_en = 1'b0; #1;
      check("flush_clean127", 64'(wb_valid), 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
